// File: rtl/mem_write_buffer_pkg.sv
// Shared types and constants for the posted-write buffer and its memory port.
package mem_write_buffer_pkg;

  localparam int unsigned AW_DEFAULT = 27;
  localparam int unsigned BEW        = 4;
  localparam int unsigned DW         = 32;

  // Memory-port sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_GAP  = 2'd3
  } wb_state_e;

  // One buffered write. The address field is sized for the default port
  // width; narrower ports zero-extend into it.
  typedef struct packed {
    logic [AW_DEFAULT-1:0] adr;
    logic [DW-1:0]         data;
    logic [BEW-1:0]        byteen;
  } wb_entry_t;

  // Packs a request into a buffer entry.
  function automatic wb_entry_t make_entry(input logic [AW_DEFAULT-1:0] adr,
                                           input logic [DW-1:0]         data,
                                           input logic [BEW-1:0]        byteen);
    wb_entry_t e;
    e.adr    = adr;
    e.data   = data;
    e.byteen = byteen;
    return e;
  endfunction

endpackage

// File: rtl/mem_write_buffer_if.sv
// Cache-controller side and external-memory side of the write buffer.
interface mem_write_buffer_if
  import mem_write_buffer_pkg::*;
#(
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Cache-controller request/response.
  logic [AW-1:0]  cadr;
  logic [DW-1:0]  cwdata;
  logic [BEW-1:0] cbyteen;
  logic           crwb;
  logic           cen;
  logic           cdone;
  logic [DW-1:0]  crdata;

  // External memory port.
  logic [AW-1:0]  memadr;
  logic [DW-1:0]  memwdata;
  logic [DW-1:0]  memrdata;
  logic [BEW-1:0] membyteen;
  logic           memrwb;
  logic           memen;
  logic           memdone;

  // Status.
  logic [CW-1:0]  wbcount;
  logic           wbempty;

  // Buffer's view.
  modport slave (
    input  cadr, cwdata, cbyteen, crwb, cen, memrdata, memdone,
    output cdone, crdata, memadr, memwdata, membyteen, memrwb, memen,
           wbcount, wbempty
  );

  // Requester / memory model view.
  modport master (
    output cadr, cwdata, cbyteen, crwb, cen, memrdata, memdone,
    input  cdone, crdata, memadr, memwdata, membyteen, memrwb, memen,
           wbcount, wbempty
  );

endinterface

// File: rtl/mem_write_buffer_wb_fifo.sv
// Circular store of posted writes with an address-match port for read hazards.
module wb_fifo
  import mem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = AW_DEFAULT,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enq_i,
  input  wb_entry_t     enq_entry_i,
  input  logic          deq_i,
  input  logic [AW-1:0] match_adr_i,
  output wb_entry_t     head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic          match_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  // Pointer, occupancy and per-slot valid next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (enq_i) begin
      tail_d          = tail_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end
    if (deq_i) begin
      head_d          = head_q + 1'b1;
      valid_d[head_q] = 1'b0;
    end
    case ({enq_i, deq_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and valid registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage, written at the tail on enqueue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq_i) begin
      mem_q[tail_q] <= enq_entry_i;
    end
  end

  // A read hits if any live entry carries its address; byte enables ignored.
  always_comb begin
    match_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (AW'(mem_q[i].adr) == match_adr_i)) begin
        match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the cache controller and external memory.
// Writes are acknowledged once queued and drain in order; non-hitting reads
// go ahead of queued writes.
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic              ph1,
  input  logic              resetb,
  mem_write_buffer_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_state_e      state_q, state_d;
  logic           memen_q, memen_d;
  logic           memrwb_q, memrwb_d;
  logic [AW-1:0]  memadr_q, memadr_d;
  logic [DW-1:0]  memwdata_q, memwdata_d;
  logic [BEW-1:0] membyteen_q, membyteen_d;
  logic           cdone_q, cdone_d;
  logic [DW-1:0]  crdata_q, crdata_d;

  wb_entry_t      enq_entry;
  wb_entry_t      head;
  logic           full;
  logic           empty;
  logic           hit;
  logic           wr_acc;
  logic           rd_req;
  logic           deq;
  logic [CW-1:0]  count;

  // A request seen during its own cdone cycle is stale and never accepted.
  assign wr_acc    = bus.cen & ~bus.crwb & ~full & ~cdone_q;
  assign rd_req    = bus.cen &  bus.crwb & ~cdone_q;
  assign deq       = (state_q == ST_WR) & bus.memdone;
  assign enq_entry = make_entry(AW_DEFAULT'(bus.cadr), bus.cwdata, bus.cbyteen);

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i       (ph1),
    .rst_ni      (resetb),
    .enq_i       (wr_acc),
    .enq_entry_i (enq_entry),
    .deq_i       (deq),
    .match_adr_i (bus.cadr),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .match_o     (hit)
  );

  // Memory-port sequencer: next state and registered port values.
  always_comb begin
    state_d     = state_q;
    memen_d     = memen_q;
    memrwb_d    = memrwb_q;
    memadr_d    = memadr_q;
    memwdata_d  = memwdata_q;
    membyteen_d = membyteen_q;
    crdata_d    = crdata_q;
    cdone_d     = wr_acc;
    case (state_q)
      ST_IDLE: begin
        if (rd_req && !hit && !wr_acc) begin
          state_d     = ST_RD;
          memen_d     = 1'b1;
          memrwb_d    = 1'b1;
          memadr_d    = bus.cadr;
          membyteen_d = bus.cbyteen;
        end else if (!empty) begin
          state_d     = ST_WR;
          memen_d     = 1'b1;
          memrwb_d    = 1'b0;
          memadr_d    = AW'(head.adr);
          memwdata_d  = head.data;
          membyteen_d = head.byteen;
        end
      end
      ST_WR: begin
        if (bus.memdone) begin
          state_d = ST_GAP;
          memen_d = 1'b0;
        end
      end
      ST_RD: begin
        if (bus.memdone) begin
          state_d  = ST_GAP;
          memen_d  = 1'b0;
          crdata_d = bus.memrdata;
          cdone_d  = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        memen_d = 1'b0;
      end
    endcase
  end

  // Sequencer and port registers; reset abandons any in-flight access.
  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      memen_q     <= 1'b0;
      memrwb_q    <= 1'b0;
      memadr_q    <= '0;
      memwdata_q  <= '0;
      membyteen_q <= '0;
      cdone_q     <= 1'b0;
      crdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      memen_q     <= memen_d;
      memrwb_q    <= memrwb_d;
      memadr_q    <= memadr_d;
      memwdata_q  <= memwdata_d;
      membyteen_q <= membyteen_d;
      cdone_q     <= cdone_d;
      crdata_q    <= crdata_d;
    end
  end

  assign bus.cdone     = cdone_q;
  assign bus.crdata    = crdata_q;
  assign bus.memen     = memen_q;
  assign bus.memrwb    = memrwb_q;
  assign bus.memadr    = memadr_q;
  assign bus.memwdata  = memwdata_q;
  assign bus.membyteen = membyteen_q;
  assign bus.wbcount   = count;
  assign bus.wbempty   = empty;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer: directed scenarios plus random
// traffic, checked against a queue-based model of the buffer's behaviour.
module tb_mem_write_buffer;
  import mem_write_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 27;

  logic ph1    = 1'b0;
  logic resetb = 1'b0;
  always #5 ph1 = ~ph1;

  mem_write_buffer_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  mem_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .ph1    (ph1),
    .resetb (resetb),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  bit             hold = 1'b0;
  bit             spur = 1'b0;
  int unsigned    lat  = 0;
  bit             use_fixed = 1'b0;
  logic [31:0]    fixed_rdata = '0;

  initial begin
    int unsigned lat_cnt;
    lat_cnt      = 0;
    bus.memdone  = 1'b0;
    bus.memrdata = '0;
    forever begin
      @(posedge ph1);
      #1;
      if (bus.memdone) begin
        bus.memdone = 1'b0;
      end else if (bus.memen && !hold) begin
        if (lat_cnt >= lat) begin
          bus.memdone  = 1'b1;
          bus.memrdata = use_fixed ? fixed_rdata : $urandom;
          lat_cnt      = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
        if (spur && !bus.memen && $urandom_range(0, 5) == 0) bus.memdone = 1'b1;
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  typedef struct {
    logic [AW-1:0] adr;
    logic [31:0]   data;
    logic [3:0]    be;
  } exp_t;

  exp_t          wq[$];
  int            m_count = 0;
  bit            exp_cdone = 1'b0;
  bit            exp_rd = 1'b0;
  logic [31:0]   exp_crdata = '0;
  bit            exp_gap = 1'b0;
  bit            hold_chk = 1'b0;
  bit            prev_memen = 1'b0;
  logic [AW-1:0] p_adr;
  logic [31:0]   p_wd;
  logic [3:0]    p_be;
  logic          p_rw;
  bit            log_rw[$];
  logic [AW-1:0] log_adr[$];

  initial begin
    bit   acc, wdone, rdone;
    int   hits;
    exp_t e;
    forever begin
      @(negedge ph1);
      if (!resetb) begin
        wq.delete();
        m_count    = 0;
        exp_cdone  = 1'b0;
        exp_rd     = 1'b0;
        exp_gap    = 1'b0;
        hold_chk   = 1'b0;
        prev_memen = 1'b0;
      end else begin
        check_eq("cdone", 64'(bus.cdone), 64'(exp_cdone));
        if (exp_rd) check_eq("crdata", 64'(bus.crdata), 64'(exp_crdata));
        check_eq("wbcount", 64'(bus.wbcount), 64'(m_count));
        check_eq("wbempty", 64'(bus.wbempty), 64'(m_count == 0));
        if (exp_gap) check_eq("gap_memen", 64'(bus.memen), 64'(0));
        if (hold_chk) begin
          check_eq("hold_memen",  64'(bus.memen),     64'(1));
          check_eq("hold_adr",    64'(bus.memadr),    64'(p_adr));
          check_eq("hold_wdata",  64'(bus.memwdata),  64'(p_wd));
          check_eq("hold_be",     64'(bus.membyteen), 64'(p_be));
          check_eq("hold_rw",     64'(bus.memrwb),    64'(p_rw));
        end
        if (bus.memen && !prev_memen) begin
          hits = 0;
          foreach (wq[i]) if (wq[i].adr == bus.memadr) hits++;
          if (bus.memrwb) begin
            check_eq("rd_issue_req", 64'(bus.cen && bus.crwb), 64'(1));
            check_eq("rd_issue_adr", 64'(bus.memadr), 64'(bus.cadr));
            check_eq("rd_issue_be",  64'(bus.membyteen), 64'(bus.cbyteen));
            check_eq("rd_hazard",    64'(hits), 64'(0));
          end else begin
            check_eq("wr_issue_nonempty", 64'(wq.size() > 0), 64'(1));
          end
        end
        wdone = bus.memen && bus.memdone && !bus.memrwb;
        rdone = bus.memen && bus.memdone &&  bus.memrwb;
        acc   = bus.cen && !bus.crwb && (m_count < DEPTH) && !exp_cdone;
        if (wdone) begin
          check_eq("wr_expected", 64'(wq.size() > 0), 64'(1));
          if (wq.size() > 0) begin
            e = wq.pop_front();
            m_count--;
            check_eq("wr_adr",   64'(bus.memadr),    64'(e.adr));
            check_eq("wr_data",  64'(bus.memwdata),  64'(e.data));
            check_eq("wr_be",    64'(bus.membyteen), 64'(e.be));
          end
          log_rw.push_back(1'b0);
          log_adr.push_back(bus.memadr);
        end
        if (rdone) begin
          log_rw.push_back(1'b1);
          log_adr.push_back(bus.memadr);
          exp_crdata = bus.memrdata;
        end
        if (acc) begin
          e.adr  = bus.cadr;
          e.data = bus.cwdata;
          e.be   = bus.cbyteen;
          wq.push_back(e);
          m_count++;
        end
        exp_cdone  = acc || rdone;
        exp_rd     = rdone;
        exp_gap    = wdone || rdone;
        hold_chk   = bus.memen && !bus.memdone;
        p_adr      = bus.memadr;
        p_wd       = bus.memwdata;
        p_be       = bus.membyteen;
        p_rw       = bus.memrwb;
        prev_memen = bus.memen;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input bit rw, input logic [AW-1:0] adr, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rdata);
    int unsigned n;
    n = 0;
    bus.cen     = 1'b1;
    bus.crwb    = rw;
    bus.cadr    = adr;
    bus.cwdata  = d;
    bus.cbyteen = be;
    do begin
      @(posedge ph1);
      #1;
      n++;
    end while (!bus.cdone && n < 400);
    check_eq("req_done", 64'(bus.cdone), 64'(1));
    rdata   = bus.crdata;
    bus.cen = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned k;
    k = 0;
    while ((!bus.wbempty || bus.memen) && k < 800) begin
      @(posedge ph1);
      #1;
      k++;
    end
    check_eq("idle_reached", 64'(bus.wbempty && !bus.memen), 64'(1));
  endtask

  task automatic wait_read_req();
    int unsigned k;
    k = 0;
    while (!(bus.cen && bus.crwb) && k < 300) begin
      @(posedge ph1);
      #1;
      k++;
    end
    check_eq("read_presented", 64'(bus.cen && bus.crwb), 64'(1));
  endtask

  task automatic check_op(input int unsigned idx, input bit rw, input logic [AW-1:0] adr);
    if (idx < log_rw.size()) begin
      check_eq($sformatf("op%0d_rw", idx),  64'(log_rw[idx]),  64'(rw));
      check_eq($sformatf("op%0d_adr", idx), 64'(log_adr[idx]), 64'(adr));
    end
  endtask

  task automatic clear_log();
    log_rw.delete();
    log_adr.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    bus.cen = 1'b0;  bus.crwb = 1'b0;  bus.cadr = '0;
    bus.cwdata = '0; bus.cbyteen = '0;

    // Reset values.
    repeat (3) @(posedge ph1);
    #1;
    check_eq("rst_memen",   64'(bus.memen),   64'(0));
    check_eq("rst_cdone",   64'(bus.cdone),   64'(0));
    check_eq("rst_wbcount", 64'(bus.wbcount), 64'(0));
    check_eq("rst_wbempty", 64'(bus.wbempty), 64'(1));
    check_eq("rst_crdata",  64'(bus.crdata),  64'(0));
    check_eq("rst_memadr",  64'(bus.memadr),  64'(0));
    resetb = 1'b1;
    repeat (2) @(posedge ph1);
    #1;

    // Single write.
    clear_log();
    lat = 2;
    do_req(1'b0, 27'h10, 32'hDEADBEEF, 4'hF, rd);
    check_eq("single_wbcount", 64'(bus.wbcount), 64'(1));
    @(posedge ph1);
    #1;
    check_eq("single_memen",  64'(bus.memen),    64'(1));
    check_eq("single_memadr", 64'(bus.memadr),   64'(27'h10));
    check_eq("single_wdata",  64'(bus.memwdata), 64'(32'hDEADBEEF));
    wait_idle();
    check_eq("single_ops", 64'(log_rw.size()), 64'(1));
    check_op(0, 1'b0, 27'h10);

    // Fill to full with memory stalled; fifth write waits for a drain.
    clear_log();
    hold = 1'b1;
    fork
      begin
        for (int i = 1; i <= 5; i++) do_req(1'b0, AW'(i), $urandom, 4'(i), rd);
      end
      begin
        repeat (15) @(posedge ph1);
        #1;
        check_eq("full_wbcount", 64'(bus.wbcount), 64'(4));
        check_eq("full_memadr",  64'(bus.memadr),  64'(1));
        hold = 1'b0;
      end
    join
    wait_idle();
    check_eq("fill_ops", 64'(log_rw.size()), 64'(5));
    for (int i = 0; i < 5; i++) check_op(i, 1'b0, AW'(i + 1));

    // Read bypasses a queued write.
    clear_log();
    hold = 1'b1;
    use_fixed = 1'b1;
    fixed_rdata = 32'hCAFEF00D;
    fork
      begin
        do_req(1'b0, 27'h20, 32'h1111_2020, 4'hF, rd);
        do_req(1'b0, 27'h21, 32'h1111_2121, 4'h3, rd);
        do_req(1'b1, 27'h40, 32'h0,         4'hF, rd);
      end
      begin
        wait_read_req();
        repeat (3) @(posedge ph1);
        #1;
        check_eq("bypass_wbcount", 64'(bus.wbcount), 64'(2));
        hold = 1'b0;
      end
    join
    check_eq("bypass_rdata", 64'(rd), 64'(32'hCAFEF00D));
    use_fixed = 1'b0;
    wait_idle();
    check_eq("bypass_ops", 64'(log_rw.size()), 64'(3));
    check_op(0, 1'b0, 27'h20);
    check_op(1, 1'b1, 27'h40);
    check_op(2, 1'b0, 27'h21);

    // Read hazard: read waits for the matching write to drain.
    clear_log();
    hold = 1'b1;
    fork
      begin
        do_req(1'b0, 27'h30, 32'hA5A5_0030, 4'hF, rd);
        do_req(1'b0, 27'h31, 32'hA5A5_0031, 4'hC, rd);
        do_req(1'b1, 27'h31, 32'h0,         4'hF, rd);
      end
      begin
        wait_read_req();
        repeat (3) @(posedge ph1);
        #1;
        check_eq("hazard_memrwb", 64'(bus.memrwb), 64'(0));
        hold = 1'b0;
      end
    join
    wait_idle();
    check_eq("hazard_ops", 64'(log_rw.size()), 64'(3));
    check_op(0, 1'b0, 27'h30);
    check_op(1, 1'b0, 27'h31);
    check_op(2, 1'b1, 27'h31);

    // Wrap-around: ten writes with a three-cycle memory latency.
    clear_log();
    lat = 3;
    for (int i = 0; i < 10; i++) do_req(1'b0, AW'(27'h100 + i), $urandom, 4'($urandom), rd);
    wait_idle();
    check_eq("wrap_ops", 64'(log_rw.size()), 64'(10));
    for (int i = 0; i < 10; i++) check_op(i, 1'b0, AW'(27'h100 + i));
    check_eq("wrap_wbempty", 64'(bus.wbempty), 64'(1));

    // Random traffic over a small address set, with stray memdone pulses.
    spur = 1'b1;
    for (int i = 0; i < 80; i++) begin
      lat = $urandom_range(0, 4);
      do_req($urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), $urandom, 4'($urandom), rd);
      repeat ($urandom_range(0, 2)) @(posedge ph1);
      #1;
    end
    wait_idle();
    spur = 1'b0;

    // Reset with writes queued and one in flight.
    clear_log();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) do_req(1'b0, AW'(27'h200 + i), $urandom, 4'hF, rd);
    repeat (2) @(posedge ph1);
    #1;
    check_eq("pre_rst_memen", 64'(bus.memen), 64'(1));
    resetb = 1'b0;
    #1;
    check_eq("midrst_memen",   64'(bus.memen),   64'(0));
    check_eq("midrst_wbcount", 64'(bus.wbcount), 64'(0));
    check_eq("midrst_wbempty", 64'(bus.wbempty), 64'(1));
    @(posedge ph1);
    #1;
    resetb = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ph1);
      #1;
      check_eq("postrst_memen", 64'(bus.memen), 64'(0));
    end
    check_eq("postrst_ops", 64'(log_rw.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog against a hung handshake.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
